// File: rtl/start_sequencer.sv
// Start sequencer for the busy-counter stage: queues single-cycle requests in a
// saturating pending count and releases them as guarded single-cycle start pulses.

module start_sequencer_checker (
  input logic clk,
  input logic reset,
  input logic start,
  input logic busy,
  input logic fire_state
);

  a_start_in_fire : assert property (@(posedge clk) disable iff (reset) start |-> fire_state);
  a_no_back2back  : assert property (@(posedge clk) disable iff (reset) start |=> !start);
  a_not_busy      : assert property (@(posedge clk) disable iff (reset) start |-> !busy);

endmodule

module start_sequencer #(
  parameter int          LGMAX = 3,
  parameter logic [15:0] GAP   = 16'd0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_request,
  input  logic             i_busy,
  input  logic             i_clear_overflow,
  output logic             o_start,
  output logic [LGMAX-1:0] o_pending,
  output logic             o_overflow
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam logic [LGMAX-1:0] PEND_ZERO = {LGMAX{1'b0}};
  localparam logic [LGMAX-1:0] PEND_ONE  = LGMAX'(1'b1);
  localparam logic [LGMAX-1:0] PEND_MAX  = {LGMAX{1'b1}};

  state_t           state_r;
  state_t           state_nxt_s;
  logic [15:0]      gapcnt_r;
  logic [15:0]      gapcnt_nxt_s;
  logic [LGMAX-1:0] pending_r;
  logic [LGMAX-1:0] pending_nxt_s;
  logic             start_r;
  logic             overflow_r;
  logic             overflow_nxt_s;
  logic             work_s;
  logic             consume_s;
  logic             drop_s;

  assign work_s = (pending_r != PEND_ZERO) || i_request;

  // State, gap counter and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r    <= ST_IDLE;
      gapcnt_r   <= 16'd0;
      pending_r  <= PEND_ZERO;
      start_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      gapcnt_r   <= gapcnt_nxt_s;
      pending_r  <= pending_nxt_s;
      start_r    <= consume_s;
      overflow_r <= overflow_nxt_s;
    end
  end

  // Next-state decision; the guard gap is reloaded when downstream goes idle
  always_comb begin
    state_nxt_s  = state_r;
    gapcnt_nxt_s = gapcnt_r;
    case (state_r)
      ST_IDLE: begin
        if (gapcnt_r != 16'd0) begin
          gapcnt_nxt_s = gapcnt_r - 16'd1;
        end else if (!i_busy && work_s) begin
          state_nxt_s = ST_FIRE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FIRE: state_nxt_s = ST_WAIT;
      ST_WAIT: begin
        if (!i_busy) begin
          state_nxt_s  = ST_IDLE;
          gapcnt_nxt_s = GAP;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      default: begin
        state_nxt_s  = ST_IDLE;
        gapcnt_nxt_s = 16'd0;
      end
    endcase
  end

  // Pending count and sticky overflow; a fire consumes one queued (or bypassed) request
  always_comb begin
    consume_s      = (state_r == ST_IDLE) && (state_nxt_s == ST_FIRE);
    drop_s         = i_request && !consume_s && (pending_r == PEND_MAX);
    pending_nxt_s  = pending_r;
    overflow_nxt_s = overflow_r;
    case ({i_request, consume_s})
      2'b10: begin
        if (drop_s) begin
          pending_nxt_s = pending_r;
        end else begin
          pending_nxt_s = pending_r + PEND_ONE;
        end
      end
      2'b01: begin
        if (pending_r == PEND_ZERO) begin
          pending_nxt_s = pending_r;
        end else begin
          pending_nxt_s = pending_r - PEND_ONE;
        end
      end
      default: pending_nxt_s = pending_r;
    endcase
    // Set wins over a simultaneous clear
    if (drop_s) begin
      overflow_nxt_s = 1'b1;
    end else if (i_clear_overflow) begin
      overflow_nxt_s = 1'b0;
    end else begin
      overflow_nxt_s = overflow_r;
    end
  end

  assign o_start    = start_r;
  assign o_pending  = pending_r;
  assign o_overflow = overflow_r;

  start_sequencer_checker u_chk (
    .clk        (i_clk),
    .reset      (i_reset),
    .start      (o_start),
    .busy       (i_busy),
    .fire_state (state_r == ST_FIRE)
  );

endmodule

// File: tb/tb_start_sequencer.sv
// Scoreboard bench for start_sequencer: expected start cycles are queued when
// requests are driven and compared as pulses appear; two instances cover GAP 0 and 3.

module tb_start_sequencer;

  logic       clk;
  logic       rst;
  logic       req0;
  logic       req3;
  logic       clr;
  logic       fb0;
  logic       busy0;
  logic       busy3;
  logic       start0;
  logic       start3;
  logic [2:0] pend0;
  logic [2:0] pend3;
  logic       ovf0;
  logic       ovf3;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n0 = 1;
  int n3 = 4;
  int cnt0 = 0;
  int cnt3 = 0;
  logic prev0 = 1'b0;
  logic prev3 = 1'b0;
  int q0[$];
  int q3[$];

  start_sequencer #(.LGMAX(3), .GAP(16'd0)) dut0 (
    .i_clk(clk), .i_reset(rst), .i_request(req0), .i_busy(busy0),
    .o_start(start0), .o_pending(pend0), .i_clear_overflow(clr), .o_overflow(ovf0)
  );

  start_sequencer #(.LGMAX(3), .GAP(16'd3)) dut3 (
    .i_clk(clk), .i_reset(rst), .i_request(req3), .i_busy(busy3),
    .o_start(start3), .o_pending(pend3), .i_clear_overflow(clr), .o_overflow(ovf3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index and downstream counter models (busy for N-1 cycles after a start)
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (start0) cnt0 <= n0 - 1;
    else if (cnt0 != 0) cnt0 <= cnt0 - 1;
    if (start3) cnt3 <= n3 - 1;
    else if (cnt3 != 0) cnt3 <= cnt3 - 1;
  end

  assign busy0 = fb0 | (cnt0 != 0);
  assign busy3 = (cnt3 != 0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic go(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Scoreboard: every start pulse must match the next expected cycle
  always @(negedge clk) begin
    if (start0 === 1'b1) begin
      if (q0.size() == 0) chk("start0_unexpected", cyc, 0);
      else chk("start0_cycle", cyc, q0.pop_front());
      if (prev0) chk("start0_back2back", 1, 0);
    end
    if (start3 === 1'b1) begin
      if (q3.size() == 0) chk("start3_unexpected", cyc, 0);
      else chk("start3_cycle", cyc, q3.pop_front());
      if (prev3) chk("start3_back2back", 1, 0);
    end
    prev0 <= (start0 === 1'b1);
    prev3 <= (start3 === 1'b1);
  end

  initial begin
    rst = 1'b1; req0 = 1'b0; req3 = 1'b0; clr = 1'b0; fb0 = 1'b0;
    @(negedge clk);
    go(3);
    chk("rst_start0", start0, 0);
    chk("rst_pend0", pend0, 0);
    chk("rst_ovf0", ovf0, 0);
    chk("rst_pend3", pend3, 0);
    rst = 1'b0;

    // Idle system: request at 5 gives start at 6, nothing queued
    go(5); req0 = 1'b1; q0.push_back(6);
    go(6); req0 = 1'b0;
    chk("idle_pend6", pend0, 0);
    chk("idle_ovf6", ovf0, 0);
    go(8);
    chk("idle_pend8", pend0, 0);

    // N=22 downstream, three back-to-back requests: spacing 24
    n0 = 22;
    go(20); req0 = 1'b1; q0.push_back(21); q0.push_back(45); q0.push_back(69);
    go(22); chk("n22_pend22", pend0, 1);
    go(23); chk("n22_pend23", pend0, 2); req0 = 1'b0;
    go(44); chk("n22_pend44", pend0, 2);
    go(45); chk("n22_pend45", pend0, 1);
    go(69); chk("n22_pend69", pend0, 0);
    go(75); chk("n22_q_empty", q0.size(), 0);

    // Busy forced high: saturate, overflow, set-wins, clear, then drain with bypass at full
    n0 = 3;
    go(100); fb0 = 1'b1; req0 = 1'b1;
    go(107); chk("sat_pend107", pend0, 7); chk("sat_ovf107", ovf0, 0);
    go(108); chk("sat_ovf108", ovf0, 1);
    go(109); chk("sat_pend109", pend0, 7); chk("sat_ovf109", ovf0, 1); clr = 1'b1;
    go(110); chk("setwins_ovf110", ovf0, 1); req0 = 1'b0;
    go(111); chk("clear_ovf111", ovf0, 0); clr = 1'b0; fb0 = 1'b0; req0 = 1'b1;
    for (int k = 0; k < 8; k++) q0.push_back(112 + 5 * k);
    go(112); req0 = 1'b0;
    chk("full_bypass_pend112", pend0, 7);
    chk("full_bypass_ovf112", ovf0, 0);
    go(117); chk("drain_pend117", pend0, 6);
    go(148); chk("drain_pend148", pend0, 0); chk("drain_ovf148", ovf0, 0);
    chk("drain_q_empty", q0.size(), 0);

    // GAP=3, N=4: starts 9 cycles apart
    go(160); req3 = 1'b1; q3.push_back(161); q3.push_back(170);
    go(162); req3 = 1'b0; chk("gap_pend162", pend3, 1);
    go(170); chk("gap_pend170", pend3, 0);
    go(175); chk("gap_q_empty", q3.size(), 0);

    // Reset during WAIT with five queued requests
    n0 = 22;
    go(200); req0 = 1'b1; q0.push_back(201);
    go(206); req0 = 1'b0; chk("rstwait_pend206", pend0, 5);
    go(208); rst = 1'b1; req0 = 1'b1;
    go(209); chk("rstwait_pend209", pend0, 0); chk("rstwait_start209", start0, 0);
    rst = 1'b0; req0 = 1'b0;
    go(210); chk("rstwait_pend210", pend0, 0);
    go(230); chk("rstwait_q_empty", q0.size(), 0); req0 = 1'b1; q0.push_back(231);
    go(231); req0 = 1'b0; chk("rstwait_pend231", pend0, 0);
    go(240); chk("final_q0_empty", q0.size(), 0); chk("final_q3_empty", q3.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
